// File: rtl/zone_timer_pkg.sv
// Shared types and helpers for the zone countdown timer: channel FSM states, MM:SS BCD
// layout, 7-segment decode and load validation.
package zone_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t dm;
    bcd_t um;
    bcd_t ds;
    bcd_t us;
  } mmss_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high segments, bit0=a .. bit6=g; non-decimal codes stay dark.
  function automatic logic [6:0] seg7(input bcd_t d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic logic bcd_valid(input mmss_t v);
    bcd_valid = (v.us <= 4'd9) && (v.ds <= 4'd5) && (v.um <= 4'd9) && (v.dm <= 4'd5);
  endfunction

endpackage

// File: rtl/zone_countdown_timer_if.sv
// Zone timer bus: scheduler-side load/start/pause and display select in, channel status
// and multiplexed display drive out.
interface zone_countdown_timer_if
  import zone_timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                load;
  logic [CW-1:0]       load_ch;
  mmss_t               load_bcd;
  logic [CHANNELS-1:0] start;
  logic [CHANNELS-1:0] pause;
  logic [CW-1:0]       disp_ch;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;
  logic                load_err;
  logic [3:0]          digit;
  logic [6:0]          segments;

  modport master (
    output load, load_ch, load_bcd, start, pause, disp_ch,
    input  busy, done, load_err, digit, segments
  );

  modport slave (
    input  load, load_ch, load_bcd, start, pause, disp_ch,
    output busy, done, load_err, digit, segments
  );

endinterface

// File: rtl/mmss_channel.sv
// One zone countdown: IDLE/RUN/PAUSED control with a BCD MM:SS borrow chain that steps
// down once per shared seconds tick.
module mmss_channel
  import zone_timer_pkg::*;
(
  input  logic  new_clock,
  input  logic  reset,
  input  logic  i_load,
  input  mmss_t i_load_val,
  input  logic  i_start,
  input  logic  i_pause,
  input  logic  i_tick,
  output mmss_t o_count,
  output logic  o_busy,
  output logic  o_done,
  output logic  o_load_rej
);
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_PAUSED = PAUSED;

  logic [1:0] r_state, w_state_nxt;
  mmss_t      r_count, w_count_nxt, w_count_dec;
  logic       r_done, w_done_nxt;
  logic       w_load_ok;

  assign w_load_ok  = bcd_valid(i_load_val);
  assign o_load_rej = i_load & ~w_load_ok;

  always_comb begin
    w_count_dec = r_count;
    if (r_count.us != 4'd0) begin
      w_count_dec.us = r_count.us - 4'd1;
    end else begin
      w_count_dec.us = 4'd9;
      if (r_count.ds != 4'd0) begin
        w_count_dec.ds = r_count.ds - 4'd1;
      end else begin
        w_count_dec.ds = 4'd5;
        if (r_count.um != 4'd0) begin
          w_count_dec.um = r_count.um - 4'd1;
        end else begin
          w_count_dec.um = 4'd9;
          w_count_dec.dm = r_count.dm - 4'd1;
        end
      end
    end
  end

  // Load aborts from any state; a pause request masks the tick in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    if (i_load && w_load_ok) begin
      w_count_nxt = i_load_val;
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_pause && (r_count != '0)) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (i_pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (i_tick && (r_count != '0)) begin
            w_count_nxt = w_count_dec;
            if (r_count == 16'h0001) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (i_start && !i_pause) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge new_clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_count = r_count;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;

endmodule

// File: rtl/zone_countdown_timer.sv
// Multi-zone MM:SS countdown timer: shared seconds prescaler, one mmss_channel per zone,
// and a scanned 4-digit 7-segment view of the selected channel.
module zone_countdown_timer
  import zone_timer_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned SCAN_DIV = 250
) (
  input logic                   new_clock,
  input logic                   reset,
  zone_countdown_timer_if.slave bus
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [SW-1:0]       r_scan_div;
  logic                w_scan_adv;
  logic [1:0]          r_scan_idx, w_scan_idx_nxt;
  logic [3:0]          r_digit;
  logic [6:0]          r_segments, w_seg_nxt;
  logic                r_load_err, w_load_err;
  logic                w_ch_ok, w_disp_ok;
  mmss_t               w_disp_count;
  bcd_t                w_disp_digit;
  mmss_t               w_count [CHANNELS];
  logic [CHANNELS-1:0] w_busy, w_done, w_rej;

  assign w_tick         = (r_presc == PW'(TICK_DIV - 1));
  assign w_scan_adv     = (r_scan_div == SW'(SCAN_DIV - 1));
  assign w_scan_idx_nxt = w_scan_adv ? r_scan_idx + 2'd1 : r_scan_idx;
  assign w_ch_ok        = (32'(bus.load_ch) < CHANNELS);
  assign w_load_err     = bus.load & (~w_ch_ok | (|w_rej));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mmss_channel u_ch (
      .new_clock  (new_clock),
      .reset      (reset),
      .i_load     (bus.load && w_ch_ok && (bus.load_ch == CW'(g))),
      .i_load_val (bus.load_bcd),
      .i_start    (bus.start[g]),
      .i_pause    (bus.pause[g]),
      .i_tick     (w_tick),
      .o_count    (w_count[g]),
      .o_busy     (w_busy[g]),
      .o_done     (w_done[g]),
      .o_load_rej (w_rej[g])
    );
  end

  // Segments are decoded for the digit being enabled next, so digit and segments switch
  // together on the same edge.
  always_comb begin
    w_disp_ok    = (32'(bus.disp_ch) < CHANNELS);
    w_disp_count = '0;
    if (w_disp_ok) w_disp_count = w_count[bus.disp_ch];
    w_disp_digit = w_disp_count.us;
    case (w_scan_idx_nxt)
      2'd0:    w_disp_digit = w_disp_count.us;
      2'd1:    w_disp_digit = w_disp_count.ds;
      2'd2:    w_disp_digit = w_disp_count.um;
      default: w_disp_digit = w_disp_count.dm;
    endcase
    w_seg_nxt = w_disp_ok ? seg7(w_disp_digit) : SEG_BLANK;
  end

  always_ff @(posedge new_clock or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_scan_div <= '0;
      r_scan_idx <= 2'd0;
      r_digit    <= 4'b0001;
      r_segments <= 7'b0111111;
      r_load_err <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + PW'(1);
      r_scan_div <= w_scan_adv ? '0 : r_scan_div + SW'(1);
      r_scan_idx <= w_scan_idx_nxt;
      r_digit    <= 4'b0001 << w_scan_idx_nxt;
      r_segments <= w_seg_nxt;
      r_load_err <= w_load_err;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.load_err = r_load_err;
  assign bus.digit    = r_digit;
  assign bus.segments = r_segments;

endmodule
